// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson ring sequencer.
//   - seq_state_e : sequencer FSM state encoding
//   - N_DEF, CYC_W_DEF, PH_W_DEF : default stage count, revolution-count width,
//     phase-index width
//   - ring_phase() : decodes a twisted-ring pattern to its state index
package johnson_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int N_DEF     = 5;
    localparam int CYC_W_DEF = 4;
    localparam int PH_W_DEF  = $clog2(2 * N_DEF);

    // The ring fills with ones from the top stage and then empties from the top,
    // so the number of set bits plus the top bit tell us where in the
    // revolution we are.
    function automatic int ring_phase(input logic [31:0] ring, input int n);
        int pc;
        pc = 0;
        for (int i = 0; i < 32; i++) begin
            if ((i < n) && ring[i]) begin
                pc++;
            end
        end
        if (ring == 32'd0) begin
            return 0;
        end else if (ring[n-1]) begin
            return pc;
        end else begin
            return (2 * n) - pc;
        end
    endfunction

endpackage

// File: rtl/johnson_ring_sequencer_ring.sv
// N-stage twisted-ring (Johnson) counter.
// Ports:
//   clk_i   : rising-edge clock
//   clear_i : synchronous active-high clear (ring -> all zeros)
//   en_i    : advance the ring by one step when high
//   ring_o  : ring state, ring_o[N-1] is the first stage
module johnson_ring #(
    parameter int N = johnson_pkg::N_DEF
) (
    input  logic         clk_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [N-1:0] ring_o
);

    logic [N-1:0] ring_q;
    logic [N-1:0] ring_d;

    // Inverted last stage feeds the first stage.
    assign ring_d = {~ring_q[0], ring_q[N-1:1]};

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            ring_q <= '0;
        end else if (en_i) begin
            ring_q <= ring_d;
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/johnson_ring_sequencer.sv
// Runs a Johnson ring through a programmed number of full revolutions under a
// start/stop handshake, decodes the ring to a phase index and reports
// completion or abort.
// Ports:
//   clk_i      : rising-edge clock
//   clear_i    : synchronous active-high reset, overrides all other inputs
//   start_i    : run request, sampled only in IDLE
//   cycles_i   : revolutions to run, sampled with start_i
//   stop_i     : abort request, sampled only in RUN
//   ring_o     : ring state (ring_o[N-1] = first stage)
//   phase_o    : decoded state index 0..2N-1
//   busy_o     : FSM not in IDLE
//   done_o     : one-cycle pulse in DONE
//   aborted_o  : run ended through stop (valid with done_o, held until next start)
//   rev_left_o : revolutions still to complete
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ring parked at zero, waiting for start
// RUN   | ring stepping, counting revolutions, stop honoured
// DRAIN | stop seen; ring steps on until it returns to zero
// DONE  | one-cycle completion pulse, then back to IDLE
module johnson_ring_sequencer
    import johnson_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CYC_W = CYC_W_DEF,
    parameter int PH_W  = PH_W_DEF
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CYC_W-1:0] cycles_i,
    input  logic             stop_i,
    output logic [N-1:0]     ring_o,
    output logic [PH_W-1:0]  phase_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [CYC_W-1:0] rev_left_o
);

    seq_state_e       state_q, state_d;
    logic [CYC_W-1:0] rev_left_q, rev_left_d;
    logic             aborted_q, aborted_d;
    logic [N-1:0]     ring;
    logic             ring_en;
    logic             wrap;
    logic             last_rev;

    johnson_ring #(.N(N)) u_ring (
        .clk_i   (clk_i),
        .clear_i (clear_i),
        .en_i    (ring_en),
        .ring_o  (ring)
    );

    assign ring_en  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // Only the last stage set means the next step lands back on all zeros.
    assign wrap     = (ring == N'(1));
    assign last_rev = (rev_left_q == CYC_W'(1));

    always_comb begin
        state_d    = state_q;
        rev_left_d = rev_left_q;
        aborted_d  = aborted_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    aborted_d  = 1'b0;
                    rev_left_d = cycles_i;
                    state_d    = (cycles_i != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    rev_left_d = rev_left_q - CYC_W'(1);
                    if (last_rev) begin
                        state_d = ST_DONE;
                    end else if (stop_i) begin
                        state_d   = ST_DONE;
                        aborted_d = 1'b1;
                    end
                end else if (stop_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wrap) begin
                    state_d    = ST_DONE;
                    aborted_d  = 1'b1;
                    rev_left_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q    <= ST_IDLE;
            rev_left_q <= '0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rev_left_q <= rev_left_d;
            aborted_q  <= aborted_d;
        end
    end

    assign ring_o     = ring;
    assign phase_o    = PH_W'(ring_phase(32'(ring), N));
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign aborted_o  = aborted_q;
    assign rev_left_o = rev_left_q;

endmodule

// File: tb/tb_johnson_ring_sequencer.sv
module tb_johnson_ring_sequencer;

    logic       clk_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] cycles_i = 4'd0;
    logic       stop_i = 1'b0;
    logic [4:0] ring_o;
    logic [3:0] phase_o;
    logic       busy_o;
    logic       done_o;
    logic       aborted_o;
    logic [3:0] rev_left_o;

    int checks = 0;
    int errors = 0;

    // Expected ring pattern for phase index 0..9 (N=5).
    logic [4:0] seq [10];

    // Observation vector: {ring, phase, busy, done, aborted, rev_left}
    logic [15:0] obs;
    assign obs = {ring_o, phase_o, busy_o, done_o, aborted_o, rev_left_o};

    johnson_ring_sequencer dut (
        .clk_i      (clk_i),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .cycles_i   (cycles_i),
        .stop_i     (stop_i),
        .ring_o     (ring_o),
        .phase_o    (phase_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .aborted_o  (aborted_o),
        .rev_left_o (rev_left_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [15:0] exp_vec(input logic [4:0] r, input logic [3:0] ph,
                                            input logic b, input logic d,
                                            input logic a, input logic [3:0] rl);
        return {r, ph, b, d, a, rl};
    endfunction

    task automatic test_reset();
        logic [15:0] e;
        clear_i  = 1'b1;
        start_i  = 1'b1;
        cycles_i = 4'd3;
        step();
        step();
        e = exp_vec(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, e);
        end
        clear_i = 1'b0;
        start_i = 1'b0;
        step();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_start_ignored: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_one_rev();
        logic [15:0] e;
        start_i  = 1'b1;
        cycles_i = 4'd1;
        step();
        start_i = 1'b0;
        e = exp_vec(5'b00000, 4'd0, 1'b1, 1'b0, 1'b0, 4'd1);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL one_rev_accept: got %h expected %h", obs, e);
        end
        for (int j = 1; j <= 9; j++) begin
            step();
            e = exp_vec(seq[j], 4'(j), 1'b1, 1'b0, 1'b0, 4'd1);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL one_rev_step%0d: got %h expected %h", j, obs, e);
            end
        end
        step();
        e = exp_vec(5'b00000, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL one_rev_done: got %h expected %h", obs, e);
        end
        step();
        e = exp_vec(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL one_rev_idle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_three_rev();
        logic [15:0] e;
        int done_cnt;
        done_cnt = 0;
        start_i  = 1'b1;
        cycles_i = 4'd3;
        step();
        start_i = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            step();
            if (done_o) done_cnt++;
            e = exp_vec(seq[j % 10], 4'(j % 10), 1'b1, (j == 30), 1'b0, 4'(3 - j / 10));
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL three_rev_step%0d: got %h expected %h", j, obs, e);
            end
        end
        for (int j = 0; j < 3; j++) begin
            step();
            if (done_o) done_cnt++;
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL three_rev_done_count: got %0d expected 1", done_cnt);
        end
        e = exp_vec(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL three_rev_idle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_stop_drain();
        logic [15:0] e;
        start_i  = 1'b1;
        cycles_i = 4'd2;
        step();
        start_i = 1'b0;
        step();
        step();
        step();
        e = exp_vec(5'b11100, 4'd3, 1'b1, 1'b0, 1'b0, 4'd2);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL drain_pre_stop: got %h expected %h", obs, e);
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        for (int j = 4; j <= 9; j++) begin
            e = exp_vec(seq[j], 4'(j), 1'b1, 1'b0, 1'b0, 4'd2);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL drain_step%0d: got %h expected %h", j, obs, e);
            end
            step();
        end
        e = exp_vec(5'b00000, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL drain_done: got %h expected %h", obs, e);
        end
        step();
        e = exp_vec(5'b00000, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL drain_idle_aborted_held: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_stop_on_wrap(input logic [3:0] cyc, input logic exp_ab,
                                     input logic [3:0] exp_rl);
        logic [15:0] e;
        start_i  = 1'b1;
        cycles_i = cyc;
        step();
        start_i = 1'b0;
        for (int j = 1; j <= 9; j++) step();
        e = exp_vec(5'b00001, 4'd9, 1'b1, 1'b0, 1'b0, cyc);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL wrap_stop_pre_c%0d: got %h expected %h", cyc, obs, e);
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        e = exp_vec(5'b00000, 4'd0, 1'b1, 1'b1, exp_ab, exp_rl);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL wrap_stop_done_c%0d: got %h expected %h", cyc, obs, e);
        end
        step();
        e = exp_vec(5'b00000, 4'd0, 1'b0, 1'b0, exp_ab, exp_rl);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL wrap_stop_idle_c%0d: got %h expected %h", cyc, obs, e);
        end
    endtask

    task automatic test_zero_cycles();
        logic [15:0] e;
        start_i  = 1'b1;
        cycles_i = 4'd0;
        step();
        start_i = 1'b0;
        e = exp_vec(5'b00000, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL zero_done: got %h expected %h", obs, e);
        end
        step();
        e = exp_vec(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL zero_idle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_clear_mid_run();
        logic [15:0] e;
        int done_cnt;
        done_cnt = 0;
        start_i  = 1'b1;
        cycles_i = 4'd2;
        step();
        start_i = 1'b0;
        for (int j = 1; j <= 4; j++) step();
        e = exp_vec(5'b11110, 4'd4, 1'b1, 1'b0, 1'b0, 4'd2);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL clear_pre: got %h expected %h", obs, e);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        e = exp_vec(5'b00000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL clear_mid_run: got %h expected %h", obs, e);
        end
        for (int j = 0; j < 12; j++) begin
            step();
            if (done_o || busy_o || (ring_o != 5'b00000)) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL clear_no_activity: got %0d active cycles expected 0", done_cnt);
        end
    endtask

    initial begin
        seq[0] = 5'b00000; seq[1] = 5'b10000; seq[2] = 5'b11000; seq[3] = 5'b11100;
        seq[4] = 5'b11110; seq[5] = 5'b11111; seq[6] = 5'b01111; seq[7] = 5'b00111;
        seq[8] = 5'b00011; seq[9] = 5'b00001;
        #2;
        test_reset();
        test_one_rev();
        test_three_rev();
        test_stop_drain();
        test_stop_on_wrap(4'd1, 1'b0, 4'd0);
        test_stop_on_wrap(4'd2, 1'b1, 4'd1);
        test_zero_cycles();
        test_clear_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/johnson_ring_sequencer.md
# johnson_ring_sequencer

Controller that sequences a 5-stage twisted-ring (Johnson) counter through a programmed number of full revolutions under a start/stop handshake. It owns the ring register, steps it only while running, decodes the ring pattern to a phase index, and reports completion or abort. It sits between control logic issuing "run N revolutions" commands and downstream logic consuming phase strobes.

## Interface
- N, default 5: number of ring stages; a revolution is 2N states.
- CYC_W, default 4: width of the revolution count.
- PH_W, default 4: phase index width, equal to clog2(2N).
- clk  in  1  rising-edge clock.
- clear  in  1  reset, synchronous and active-high; it has priority over every other input.
- start  in  1  request to run; sampled only in IDLE.
- cycles  in  CYC_W  number of revolutions; sampled with start.
- stop  in  1  abort request; sampled only in RUN.
- ring  out  N  ring state; ring[N-1] is the first stage (out_a), ring[0] is the last stage (out_e).
- phase  out  PH_W  decoded state index 0..2N-1.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- aborted  out  1  valid with done; high if the run ended through stop.
- rev_left  out  CYC_W  revolutions still to complete.

## Operation
- Ring step: ring <= {~ring[0], ring[N-1:1]}. For N=5 the sequence is 00000, 10000, 11000, 11100, 11110, 11111, 01111, 00111, 00011, 00001, then back to 00000.
- The ring steps only in RUN and DRAIN. In all other states it holds.
- Phase decoding is combinational from ring, with zero latency:
  - ring == 0 gives phase 0.
  - ring[N-1] == 1 gives phase = popcount(ring).
  - Otherwise phase = 2N − popcount(ring).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, start=1, cycles≠0: go to RUN; rev_left <= cycles; aborted <= 0.
  - IDLE, start=1, cycles=0: go to DONE; the ring does not move; aborted <= 0.
  - RUN: step each cycle. Define wrap as ring == {0…01}, meaning the next step returns the ring to 0. On wrap, rev_left decrements. When wrap occurs with rev_left == 1, go to DONE.
  - RUN, stop=1, no final wrap: go to DRAIN; the ring steps on the same edge.
  - RUN, stop=1 together with a wrap: go to DONE. aborted <= (rev_left ≠ 1).
  - DRAIN: step each cycle. On wrap, go to DONE with aborted <= 1 and rev_left <= 0.
  - DONE: done=1 for one cycle, then go to IDLE.
- start is ignored while busy. stop is ignored outside RUN.
- The ring always ends a run at 00000.

## Timing
- Reset values (next edge with clear=1): ring=0, phase=0, busy=0, done=0, aborted=0, rev_left=0, state=IDLE.
- clear mid-run has the same effect: the run is discarded and done is not pulsed.
- Start accepted at edge k: busy=1 after edge k, and the ring shows 10000 after edge k+1.
- A run of C revolutions: the ring returns to 0 and DONE is entered at edge k+2N·C. done is high for that cycle. busy goes low after edge k+2N·C+1.
- cycles=0: done is high for the cycle after edge k. busy is high for exactly that one cycle.
- rev_left changes on the wrap edge. aborted holds its value until the next accepted start.

## Structure
- Shared package johnson_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default N, CYC_W, PH_W;
  - a function returning the phase index from a ring value.
- One sub-module, johnson_ring: the N-stage twisted ring with an enable input and synchronous clear. The sequencer drives its enable; ring and phase decoding stay outside it.

## Test plan
- clear for 2 cycles → all outputs 0, state IDLE. start=1 asserted together with clear → ignored.
- start with cycles=1 → ring steps 10000 … 00001, then 00000. phase reads 1..9 then 0. done pulses at edge k+10 with aborted=0. busy low after edge k+11.
- start with cycles=3 → 30 steps. rev_left reads 3→2→1→0 on the wrap edges. A single done pulse.
- cycles=2, stop pulsed while ring=11100 in the first revolution → DRAIN through 00001. done at ring 00000 with aborted=1 and rev_left=0.
- stop asserted while ring=00001 in the last revolution → DONE with aborted=0. The same stop in a non-last revolution → aborted=1.
- cycles=0 → done on the next cycle and the ring stays 00000. clear asserted at ring=11110 → ring=00000 and IDLE next cycle, with no done pulse.
